// File: rtl/piggy_uart_pkg.sv
// +----------------------------------------------------------------------+
// | piggy_uart_pkg: shared UART constants, receiver states, commands.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package piggy_uart_pkg;

  // Default bit period; the transmitter uses the same value
  localparam int c_clks_per_bit_default = 87;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_BREAK   = 3'd4,
    ST_CLEANUP = 3'd5
  } rx_state_t;

  localparam logic [7:0] c_cmd_report_uc = 8'h52;
  localparam logic [7:0] c_cmd_report_lc = 8'h72;
  localparam logic [7:0] c_cmd_clear_uc  = 8'h43;
  localparam logic [7:0] c_cmd_clear_lc  = 8'h63;

endpackage

`default_nettype wire

// File: rtl/piggy_uart_rx_core.sv
// +----------------------------------------------------------------------+
// | piggy_uart_rx_core: 8N1 bit-level receiver with break handling.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module piggy_uart_rx_core
  import piggy_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit_default
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_DV,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err
);

  localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_cnt_mid  = c_cnt_w'((CLKS_PER_BIT - 1) / 2);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);

  logic [1:0]         r_sync;
  logic               w_rx_s;
  rx_state_t          r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;

  assign w_rx_s = r_sync[1];

  // Synchronizer resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_Rx_Serial};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      o_Rx_Byte   <= 8'h00;
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Rx_Active <= 1'b0;
    end else begin
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= 3'd0;
          if (!w_rx_s) begin
            r_state     <= ST_START;
            o_Rx_Active <= 1'b1;
          end
        end
        ST_START: begin
          if (r_cnt == c_cnt_mid) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state <= ST_DATA;
            end else begin
              r_state     <= ST_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == c_cnt_last) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= 3'd0;
              r_state   <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == c_cnt_last) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              o_Rx_Byte   <= r_shift;
              o_Rx_DV     <= 1'b1;
              o_Rx_Active <= 1'b0;
              r_state     <= ST_CLEANUP;
            end else begin
              o_Frame_Err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // A held-low line is a break, not a new start bit
        ST_BREAK: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state     <= ST_IDLE;
            o_Rx_Active <= 1'b0;
          end
        end
        ST_CLEANUP: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cnt       <= '0;
          r_state     <= ST_IDLE;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/piggy_uart_rx_cmd.sv
// +----------------------------------------------------------------------+
// | piggy_uart_rx_cmd: UART receiver with Report/Clear command decode.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module piggy_uart_rx_cmd
  import piggy_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit_default
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_DV,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err,
  output logic       o_Cmd_Report,
  output logic       o_Cmd_Clear
);

  logic [7:0] w_rx_byte;
  logic       w_rx_dv;

  piggy_uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Rx_Byte   (w_rx_byte),
    .o_Rx_DV     (w_rx_dv),
    .o_Rx_Active (o_Rx_Active),
    .o_Frame_Err (o_Frame_Err)
  );

  assign o_Rx_Byte = w_rx_byte;
  assign o_Rx_DV   = w_rx_dv;

  // Decoded off the registered byte so commands line up with the DV pulse
  assign o_Cmd_Report = w_rx_dv &&
                        ((w_rx_byte == c_cmd_report_uc) || (w_rx_byte == c_cmd_report_lc));
  assign o_Cmd_Clear  = w_rx_dv &&
                        ((w_rx_byte == c_cmd_clear_uc) || (w_rx_byte == c_cmd_clear_lc));

endmodule

`default_nettype wire

// File: tb/tb_piggy_uart_rx_cmd.sv
// +----------------------------------------------------------------------+
// | tb_piggy_uart_rx_cmd: self-checking bench for piggy_uart_rx_cmd.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_piggy_uart_rx_cmd;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_dv, rx_active, frame_err, cmd_report, cmd_clear;

  always #5 clk = ~clk;

  piggy_uart_rx_cmd #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_Rx_Serial  (rx),
    .o_Rx_Byte    (rx_byte),
    .o_Rx_DV      (rx_dv),
    .o_Rx_Active  (rx_active),
    .o_Frame_Err  (frame_err),
    .o_Cmd_Report (cmd_report),
    .o_Cmd_Clear  (cmd_clear)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         dv_cnt = 0, err_cnt = 0, rep_cnt = 0, clr_cnt = 0;
  logic [7:0] model_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic is_report(input logic [7:0] b);
    return (b == 8'h52) || (b == 8'h72);
  endfunction

  function automatic logic is_clear(input logic [7:0] b);
    return (b == 8'h43) || (b == 8'h63);
  endfunction

  // Every frame the stimulus sends yields exactly one expected event, in order
  always @(negedge clk) begin
    ev_t  e;
    logic dv_now;
    if (!rst_n) begin
      model_byte = 8'h00;
    end else begin
      dv_now = 1'b0;
      if (rx_dv || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, rx_dv, frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {30'd0, rx_dv, frame_err}, e.is_err ? 32'd1 : 32'd2);
          if (!e.is_err) begin
            model_byte = e.data;
            dv_now     = 1'b1;
          end
        end
      end
      if (rx_dv)      dv_cnt++;
      if (frame_err)  err_cnt++;
      if (cmd_report) rep_cnt++;
      if (cmd_clear)  clr_cnt++;
      chk("rx_byte", {24'd0, rx_byte}, {24'd0, model_byte});
      chk("cmd_report", {31'd0, cmd_report}, {31'd0, dv_now && is_report(model_byte)});
      chk("cmd_clear", {31'd0, cmd_clear}, {31'd0, dv_now && is_clear(model_byte)});
    end
  end

  task automatic drive_bits(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int stop_len);
    ev_t e;
    e.is_err = !stop_ok;
    e.data   = b;
    exp_q.push_back(e);
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
    drive_bits(stop_ok, stop_len);
  endtask

  initial begin
    logic [7:0] b;
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_byte", {24'd0, rx_byte}, 32'h00);
    chk("reset_dv", {31'd0, rx_dv}, 32'd0);
    chk("reset_err", {31'd0, frame_err}, 32'd0);
    chk("reset_active", {31'd0, rx_active}, 32'd0);
    chk("reset_cmds", {30'd0, cmd_report, cmd_clear}, 32'd0);
    rst_n = 1'b1;
    drive_bits(1'b1, 5);

    // 'R' with good stop
    send_byte(8'h52, 1'b1, CPB);
    drive_bits(1'b1, 8);
    chk("r_byte", {24'd0, rx_byte}, 32'h52);
    chk("r_dv_cnt", dv_cnt, 1);
    chk("r_report_cnt", rep_cnt, 1);
    chk("r_clear_cnt", clr_cnt, 0);

    // 'c' then 0xA5 back-to-back
    send_byte(8'h63, 1'b1, CPB);
    send_byte(8'hA5, 1'b1, CPB);
    drive_bits(1'b1, 8);
    chk("pair_byte", {24'd0, rx_byte}, 32'hA5);
    chk("pair_dv_cnt", dv_cnt, 3);
    chk("pair_clear_cnt", clr_cnt, 1);
    chk("pair_report_cnt", rep_cnt, 1);

    // 'C' with low stop, line held low 40 cycles
    send_byte(8'h43, 1'b0, 40);
    chk("break_active", {31'd0, rx_active}, 32'd1);
    chk("break_err_cnt", err_cnt, 1);
    drive_bits(1'b1, 6);
    chk("break_release_active", {31'd0, rx_active}, 32'd0);
    chk("break_byte_kept", {24'd0, rx_byte}, 32'hA5);
    chk("break_dv_cnt", dv_cnt, 3);
    chk("break_clear_cnt", clr_cnt, 1);

    // 5-cycle glitch: start detected, then rejected at mid-bit
    drive_bits(1'b0, 5);
    drive_bits(1'b1, 3);
    chk("glitch_active_seen", {31'd0, rx_active}, 32'd1);
    drive_bits(1'b1, 20);
    chk("glitch_active_idle", {31'd0, rx_active}, 32'd0);
    chk("glitch_dv_cnt", dv_cnt, 3);
    chk("glitch_err_cnt", err_cnt, 1);

    // Reset during bit 4 of 'r'
    b = 8'h72;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bits(b[i], CPB);
    drive_bits(b[4], 8);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    chk("midreset_byte", {24'd0, rx_byte}, 32'h00);
    chk("midreset_active", {31'd0, rx_active}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_bits(1'b1, 40);
    chk("aborted_active", {31'd0, rx_active}, 32'd0);
    chk("aborted_dv_cnt", dv_cnt, 3);
    chk("aborted_report_cnt", rep_cnt, 1);
    send_byte(8'h72, 1'b1, CPB);
    drive_bits(1'b1, 8);
    chk("second_r_byte", {24'd0, rx_byte}, 32'h72);
    chk("second_r_dv_cnt", dv_cnt, 4);
    chk("second_r_report_cnt", rep_cnt, 2);
    chk("final_err_cnt", err_cnt, 1);
    chk("pending_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/piggy_uart_rx_cmd.md
PIGGY_UART_RX_CMD -- requirements
Module: piggy_uart_rx_cmd

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: clk cycles per UART bit (8N1, LSB first); legal range 4..4095.
REQ-002 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port i_Rx_Serial, input, 1: asynchronous serial line, idle high.
REQ-005 SHALL have port o_Rx_Byte, output, 8: last byte received with a valid stop bit.
REQ-006 SHALL have port o_Rx_DV, output, 1: one-cycle pulse when o_Rx_Byte is updated.
REQ-007 SHALL have port o_Rx_Active, output, 1: high from start-bit detection until return to IDLE.
REQ-008 SHALL have port o_Frame_Err, output, 1: one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port o_Cmd_Report, output, 1: one-cycle pulse on receipt of 'R' (0x52) or 'r' (0x72).
REQ-010 SHALL have port o_Cmd_Clear, output, 1: one-cycle pulse on receipt of 'C' (0x43) or 'c' (0x63).

Function
REQ-011 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rx_s), which adds 2 cycles of input latency.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK, CLEANUP.
REQ-013 In IDLE, when rx_s==0, SHALL clear the bit counter and enter START.
REQ-014 In START, at count (CLKS_PER_BIT-1)/2, SHALL sample rx_s: 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no outputs pulsed).
REQ-015 In DATA, SHALL sample rx_s at each count CLKS_PER_BIT-1 into bit index 0..7 (LSB first); after index 7 SHALL enter STOP.
REQ-016 In STOP, at count CLKS_PER_BIT-1, if rx_s==1: o_Rx_Byte <= shift register and o_Rx_DV=1 for exactly one cycle; then CLEANUP.
REQ-017 In STOP, if rx_s==0: o_Frame_Err=1 for one cycle; o_Rx_Byte unchanged; no command pulses; then BREAK.
REQ-018 BREAK SHALL hold until rx_s==1, then go to IDLE; a low line SHALL NOT restart reception.
REQ-019 CLEANUP SHALL last exactly one cycle, then go to IDLE.
REQ-020 o_Cmd_Report/o_Cmd_Clear SHALL assert in the same cycle as o_Rx_DV, decoded from the accepted byte; any other byte SHALL produce no command pulse.
REQ-021 o_Rx_DV, o_Frame_Err and the command pulses SHALL never be high for more than one cycle per frame.
REQ-022 o_Rx_Active SHALL be high in START, DATA, STOP and BREAK, and low in IDLE and CLEANUP.
REQ-023 Baud counter width SHALL be ceil(log2(CLKS_PER_BIT)) bits; the counter SHALL be cleared on every state transition and SHALL never wrap.

Reset
REQ-024 On clk edge with rst_n==0: state=IDLE, counters=0, shift register=0, synchronizer flops=1, o_Rx_Byte=0x00, all pulse outputs=0, o_Rx_Active=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait for a fresh falling edge.

Structure
REQ-026 Shared package piggy_uart_pkg SHALL hold the default CLKS_PER_BIT (shared with the transmitter), the state encoding, and the ASCII command constants 0x52/0x72/0x43/0x63.
REQ-027 The bit-level receiver (REQ-011..REQ-023) SHALL be sub-module piggy_uart_rx_core; command decoding SHALL be inline in piggy_uart_rx_cmd.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 0x52, stop=1 -> one o_Rx_DV with o_Rx_Byte=0x52 and o_Cmd_Report high in the same cycle; o_Cmd_Clear stays 0.
REQ-029 Send 0x63, then 0xA5 back-to-back -> Clear pulse with byte 0x63; then DV with byte 0xA5 and no command pulse.
REQ-030 Send 0x43 with stop=0, line held low for 40 cycles -> one o_Frame_Err; no DV; o_Rx_Byte keeps its previous value; o_Rx_Active=1 until the line rises.
REQ-031 Drive a 5-cycle low glitch -> no DV and no Frame_Err; state returns to IDLE.
REQ-032 Assert rst_n=0 during bit 4 of 0x72, then send 0x72 after release -> no pulse from the aborted frame; one Report pulse from the second frame.
